// File: rtl/intr_sched_pkg.sv
// Shared types and limits for the interrupt scheduler.
// Also holds a helper that sizes source-id fields.
package intr_sched_pkg;

  localparam int INTR_NSRC_MAX = 16;

  typedef enum logic [1:0] {
    IS_IDLE    = 2'd0,
    IS_ISSUE   = 2'd1,
    IS_SERVICE = 2'd2
  } INTR_STATE;

  // Width of a source-id field; kept at least 1 bit so NSRC=1 still has a port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_sched_if.sv
// Signal bundle between the core/peripherals and the interrupt scheduler.
// master = core and peripheral side, slave = scheduler.
interface intr_sched_if
  import intr_sched_pkg::*;
#(
  parameter int NSRC = 4
);

  localparam int IDW = id_width(NSRC);

  // Handshake: the scheduler raises icall for exactly one cycle, and only when
  // boundary and intr_en were high in the cycle before it. After that, busy stays
  // high until the core pulses ack for one cycle or the watchdog fires. An ack
  // is only honoured while the scheduler is in service.
  logic [NSRC-1:0] src_req;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            intr_en;
  logic            boundary;
  logic            ack;
  logic            icall;
  logic [IDW-1:0]  irq_id;
  logic            busy;
  logic [NSRC-1:0] pending;
  logic            timeout;
  INTR_STATE       dbg_state;

  modport master (
    output src_req, mask_we, mask_wdata, intr_en, boundary, ack,
    input  icall, irq_id, busy, pending, timeout, dbg_state
  );

  modport slave (
    input  src_req, mask_we, mask_wdata, intr_en, boundary, ack,
    output icall, irq_id, busy, pending, timeout, dbg_state
  );

endinterface

// File: rtl/intr_sched_prio_enc.sv
// Combinational fixed-priority encoder. The lowest set index wins.
// valid is low and idx is 0 when no request bit is set.
module prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning from the top down lets the lowest set index overwrite the others.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: edge-detects source requests, picks one by fixed priority,
// issues an ICALL at an instruction boundary and holds it until ACK or watchdog.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input logic        clk,
  input logic        rst_n,
  intr_sched_if.slave bus
);

  localparam int IDW = id_width(NSRC);
  localparam int CW  = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  INTR_STATE       state, state_n;
  logic [NSRC-1:0] pending_r, pending_n;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] src_prev;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IDW-1:0]  irq_id_r, irq_id_n;
  logic [IDW-1:0]  enc_idx;
  logic            enc_valid;
  logic            timeout_r, timeout_n;

  assign rise     = bus.src_req & ~src_prev;
  assign eligible = pending_r & mask_r;

  prio_enc #(.N(NSRC), .IW(IDW)) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    state_n   = state;
    pending_n = pending_r;
    cnt_n     = cnt;
    irq_id_n  = irq_id_r;
    timeout_n = timeout_r;
    case (state)
      IS_IDLE: begin
        if (enc_valid && bus.intr_en && bus.boundary) begin
          state_n  = IS_ISSUE;
          irq_id_n = enc_idx;
        end
      end
      IS_ISSUE: begin
        state_n = IS_SERVICE;
        cnt_n   = '0;
      end
      IS_SERVICE: begin
        if (bus.ack) begin
          pending_n[irq_id_r] = 1'b0;
          state_n             = IS_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_n = 1'b1;
          state_n   = IS_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IS_IDLE;
    endcase
    // A new edge is applied after the ack clear, so a same-cycle request re-pends.
    pending_n = pending_n | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IS_IDLE;
      pending_r <= '0;
      mask_r    <= '0;
      src_prev  <= '0;
      cnt       <= '0;
      irq_id_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_n;
      pending_r <= pending_n;
      mask_r    <= bus.mask_we ? bus.mask_wdata : mask_r;
      src_prev  <= bus.src_req;
      cnt       <= cnt_n;
      irq_id_r  <= irq_id_n;
      timeout_r <= timeout_n;
    end
  end

  assign bus.icall     = (state == IS_ISSUE);
  assign bus.busy      = (state != IS_IDLE);
  assign bus.irq_id    = irq_id_r;
  assign bus.pending   = pending_r;
  assign bus.timeout   = timeout_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_intr_sched.sv
// Randomized and directed bench for intr_sched, checked against a behavioural model
// and a queue of expected ICALL source ids.
module tb_intr_sched;

  localparam int NSRC = 4;
  localparam int TO   = 8;

  logic clk;
  logic rst_n;

  intr_sched_if #(.NSRC(NSRC)) bus ();

  intr_sched #(.NSRC(NSRC), .ACK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- drive values (held between ticks) ----------------
  logic [3:0] d_src = '0;
  logic       d_mw  = 1'b0;
  logic [3:0] d_mwd = '0;
  logic       d_ien = 1'b0;
  logic       d_bnd = 1'b0;
  logic       d_ack = 1'b0;
  logic       d_rn  = 1'b0;

  // ---------------- behavioural model ----------------
  logic [3:0] m_pend, m_mask, m_prev;
  bit         m_issuing, m_serving, m_tmo;
  int         m_age, m_cur;

  logic [1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_issuing = 0; m_serving = 0; m_tmo = 0;
    m_age = 0; m_cur = 0;
  endtask

  // One clock edge of the scheduler's documented behaviour.
  task automatic model_step();
    logic [3:0] rise, elig;
    logic [3:0] cur_v;
    if (!d_rn) begin
      model_reset();
      return;
    end
    rise = d_src & ~m_prev;
    elig = m_pend & m_mask;
    if (m_serving) begin
      m_age++;
      if (d_ack) begin
        m_pend[m_cur] = 1'b0;
        m_serving = 0;
      end else if (m_age == TO) begin
        m_tmo = 1;
        m_serving = 0;
      end
    end else if (m_issuing) begin
      m_issuing = 0;
      m_serving = 1;
      m_age = 0;
    end else if (elig != 0 && d_ien && d_bnd) begin
      m_cur = lowest(elig);
      m_issuing = 1;
      cur_v = 4'(m_cur);
      exp_q.push_back(cur_v[1:0]);
    end
    m_pend = m_pend | rise;
    if (d_mw) m_mask = d_mwd;
    m_prev = d_src;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    rst_n          = d_rn;
    bus.src_req    = d_src;
    bus.mask_we    = d_mw;
    bus.mask_wdata = d_mwd;
    bus.intr_en    = d_ien;
    bus.boundary   = d_bnd;
    bus.ack        = d_ack;
    model_step();
    @(posedge clk);
    #1;
    chk("icall",   8'(bus.icall),   8'(m_issuing));
    chk("busy",    8'(bus.busy),    8'(m_issuing | m_serving));
    chk("pending", 8'(bus.pending), 8'(m_pend));
    chk("timeout", 8'(bus.timeout), 8'(m_tmo));
    if (m_issuing || m_serving) chk("irq_id", 8'(bus.irq_id), 8'(m_cur));
    d_mw  = 1'b0;
    d_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.icall === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL icall_unexpected: got irq_id %0d expected no icall at %0t", bus.irq_id, $time);
      end else begin
        chk("icall_id", 8'(bus.irq_id), 8'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.src_req = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.intr_en = 1'b0; bus.boundary = 1'b0; bus.ack = 1'b0;
    model_reset();

    // Reset, then a quiet idle period.
    d_rn = 1'b0; ticks(2);
    d_rn = 1'b1; ticks(20);

    // Basic request on source 2.
    d_mw = 1'b1; d_mwd = 4'b1111; d_ien = 1'b1; d_bnd = 1'b1; tick();
    d_src = 4'b0100; ticks(4);
    d_ack = 1'b1; tick();
    ticks(2);
    d_src = 4'b0000; tick();

    // Simultaneous requests on sources 3 and 1.
    d_src = 4'b1010; ticks(4);
    d_ack = 1'b1; tick();
    ticks(4);
    d_ack = 1'b1; tick();
    ticks(2);
    d_src = 4'b0000; tick();

    // Gating by intr_en and boundary, then masking.
    d_ien = 1'b0; d_bnd = 1'b0;
    d_mw = 1'b1; d_mwd = 4'b1110; tick();
    d_src = 4'b0001; ticks(4);
    d_ien = 1'b1; ticks(4);
    d_ien = 1'b0; d_bnd = 1'b1; ticks(4);
    d_ien = 1'b1; ticks(4);
    d_mw = 1'b1; d_mwd = 4'b1111; ticks(4);
    d_ack = 1'b1; tick();
    ticks(2);

    // Ack in the same cycle as a new edge on the source in service.
    d_src = 4'b0000; ticks(2);
    d_src = 4'b0001; ticks(3);
    d_src = 4'b0000; tick();
    d_src = 4'b0001; d_ack = 1'b1; tick();
    ticks(4);
    d_ack = 1'b1; tick();
    d_src = 4'b0000; ticks(2);

    // Watchdog with no ack, then reset while in service.
    d_src = 4'b0100; ticks(14);
    d_rn = 1'b0; d_src = 4'b0000; tick();
    d_rn = 1'b1; ticks(3);

    // Randomized traffic.
    d_mw = 1'b1; d_mwd = 4'b1111; tick();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) d_src = d_src ^ 4'($urandom_range(0, 15));
      d_mw  = ($urandom_range(0, 15) == 0);
      d_mwd = 4'($urandom_range(0, 15));
      d_ien = ($urandom_range(0, 7) != 0);
      d_bnd = ($urandom_range(0, 3) != 0);
      d_ack = ($urandom_range(0, 4) == 0);
      d_rn  = (!m_issuing && $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    // Drain: let any final ICALL reach the monitor.
    d_rn = 1'b1; d_ien = 1'b0; d_ack = 1'b0; ticks(3);
    chk("exp_q_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
